debug_report_tx: RTL and testbench

- Transmit-side companion to the debug capture path.
- When debug mode is enabled, every received frame and every register write-back is reported to the host over a UART line (8N1, LSB first).
- Sits beside the debug capture block. It uses the same frame_valid, frame, data_out_valid, data_out and channel inputs, and drives the debug TX pin.

---
 rtl/debug_report_tx.sv | 161 ++++++++++++++++
 tb/tb_debug_report_tx.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_report_tx.sv
// debug_report_tx: reports received frames and register write-backs
// to the host as 8N1 UART bytes while debug mode is enabled.
module debug_report_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       debug,
   input  logic       frame_valid,
   input  logic [8:0] frame,
   input  logic       data_out_valid,
   input  logic [3:0] data_out,
   input  logic [1:0] channel,
   output logic       tx,
   output logic       busy,
   output logic       overrun
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift;
   logic [7:0]  b_byte;
   logic        b_pend;
   logic        fr_pend;
   logic        rr_pend;
   logic [8:0]  fr_slot;
   logic [5:0]  rr_slot;
   logic        tick;
   logic        take_fr;
   logic        take_rr;
   logic        take_b;
   logic        shift_en;

   assign tick = (cnt == 16'(CLKS_PER_BIT - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state, slot consumption and line level
   always_comb begin
      state_nxt = state;
      take_fr   = 1'b0;
      take_rr   = 1'b0;
      take_b    = 1'b0;
      shift_en  = 1'b0;
      tx        = 1'b1;
      unique case (state)
         IDLE: begin
            if (debug && fr_pend) begin
               take_fr   = 1'b1;
               state_nxt = START;
            end else if (debug && rr_pend) begin
               take_rr   = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            tx = 1'b0;
            if (tick) state_nxt = DATA;
         end
         DATA: begin
            tx = shift[0];
            if (tick) begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               // byte B only follows while reporting is still enabled
               if (b_pend && debug) begin
                  take_b    = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Baud and bit counters restart on every state entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         bit_cnt <= '0;
      end else begin
         if (state_nxt != state || tick) cnt <= '0;
         else                            cnt <= cnt + 16'd1;
         if (state != DATA) bit_cnt <= '0;
         else if (tick)     bit_cnt <= bit_cnt + 3'd1;
      end
   end

   // Shift register and the held second byte of a frame report
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift  <= '0;
         b_byte <= '0;
         b_pend <= 1'b0;
      end else begin
         if (take_fr) begin
            shift  <= {2'b01, 5'b00000, fr_slot[8]};
            b_byte <= fr_slot[7:0];
            b_pend <= 1'b1;
         end else if (take_rr) begin
            shift <= {2'b10, rr_slot};
         end else if (take_b) begin
            shift  <= b_byte;
            b_pend <= 1'b0;
         end else if (shift_en) begin
            shift <= {1'b0, shift[7:1]};
         end
         if (state == STOP && tick && !take_b) b_pend <= 1'b0;
      end
   end

   // Pending slots and sticky overrun; a same-cycle consume is not an overrun
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fr_pend <= 1'b0;
         rr_pend <= 1'b0;
         fr_slot <= '0;
         rr_slot <= '0;
         overrun <= 1'b0;
      end else if (!debug) begin
         fr_pend <= 1'b0;
         rr_pend <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (frame_valid) begin
            fr_slot <= frame;
            fr_pend <= 1'b1;
            if (fr_pend && !take_fr) overrun <= 1'b1;
         end else if (take_fr) begin
            fr_pend <= 1'b0;
         end
         if (data_out_valid) begin
            rr_slot <= {channel, data_out};
            rr_pend <= 1'b1;
            if (rr_pend && !take_rr) overrun <= 1'b1;
         end else if (take_rr) begin
            rr_pend <= 1'b0;
         end
      end
   end

   // Busy while a byte is on the line or a report waits
   always_comb begin
      busy = (state != IDLE) | fr_pend | rr_pend;
   end

endmodule

// File: tb/tb_debug_report_tx.sv
// tb_debug_report_tx: directed tests of the debug report UART
// transmitter with a 4-clock bit time.
module tb_debug_report_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       debug = 1'b0;
   logic       frame_valid = 1'b0;
   logic [8:0] frame = '0;
   logic       data_out_valid = 1'b0;
   logic [3:0] data_out = '0;
   logic [1:0] channel = '0;
   logic       tx;
   logic       busy;
   logic       overrun;

   int errors = 0;
   int checks = 0;

   debug_report_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst(rst),
      .debug(debug),
      .frame_valid(frame_valid),
      .frame(frame),
      .data_out_valid(data_out_valid),
      .data_out(data_out),
      .channel(channel),
      .tx(tx),
      .busy(busy),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Receive one byte: gap = negedges waited for the start bit
   task automatic rx_byte(output logic [7:0] b, output int gap,
                          output logic ok);
      int n;
      n = 0;
      ok = 1'b1;
      b = '0;
      while (tx !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      gap = n;
      if (tx !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      repeat (CPB / 2) @(negedge clk);
      if (tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
   endtask

   task automatic pulse_rr(input logic [1:0] ch, input logic [3:0] d);
      channel = ch;
      data_out = d;
      data_out_valid = 1'b1;
      @(negedge clk);
      data_out_valid = 1'b0;
   endtask

   task automatic pulse_fr(input logic [8:0] f);
      frame = f;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
   endtask

   task automatic test_reset();
      #3 rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx got %b want 1", tx);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_overrun got %b want 0", overrun);
      end
      rst = 1'b0;
      debug = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_rr();
      logic [7:0] b;
      int g;
      logic ok;
      pulse_rr(2'b11, 4'hA);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rr_busy_pend got %b want 1", busy);
      end
      rx_byte(b, g, ok);
      checks++;
      if (g !== 1) begin
         errors++;
         $display("FAIL rr_latency got %0d want 1", g);
      end
      checks++;
      if (b !== 8'hBA || ok !== 1'b1) begin
         errors++;
         $display("FAIL rr_byte got %h ok=%b want ba ok=1", b, ok);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rr_busy_stop got %b want 1", busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL rr_idle got busy=%b tx=%b want 0 1", busy, tx);
      end
   endtask

   task automatic test_fr();
      logic [7:0] b;
      int g;
      logic ok;
      pulse_fr(9'h1C5);
      rx_byte(b, g, ok);
      checks++;
      if (b !== 8'h41 || g !== 1 || ok !== 1'b1) begin
         errors++;
         $display("FAIL fr_a got %h gap=%0d ok=%b want 41 1 1", b, g, ok);
      end
      rx_byte(b, g, ok);
      checks++;
      if (b !== 8'hC5 || g !== 2 || ok !== 1'b1) begin
         errors++;
         $display("FAIL fr_b got %h gap=%0d ok=%b want c5 2 1", b, g, ok);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL fr_busy got %b want 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b;
      int g;
      logic ok;
      frame = 9'h012;
      channel = 2'd1;
      data_out = 4'd3;
      frame_valid = 1'b1;
      data_out_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      data_out_valid = 1'b0;
      rx_byte(b, g, ok);
      checks++;
      if (b !== 8'h40 || g !== 1 || ok !== 1'b1) begin
         errors++;
         $display("FAIL b2b_a got %h gap=%0d ok=%b want 40 1 1", b, g, ok);
      end
      rx_byte(b, g, ok);
      checks++;
      if (b !== 8'h12 || g !== 2 || ok !== 1'b1) begin
         errors++;
         $display("FAIL b2b_b got %h gap=%0d ok=%b want 12 2 1", b, g, ok);
      end
      rx_byte(b, g, ok);
      checks++;
      if (b !== 8'h93 || g !== 3 || ok !== 1'b1) begin
         errors++;
         $display("FAIL b2b_rr got %h gap=%0d ok=%b want 93 3 1", b, g, ok);
      end
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL b2b_overrun got %b want 0", overrun);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_overrun();
      logic [7:0] b;
      int g;
      logic ok;
      pulse_fr(9'h0AA);
      fork
         rx_byte(b, g, ok);
         begin
            repeat (10) @(negedge clk);
            pulse_rr(2'd0, 4'd1);
            repeat (5) @(negedge clk);
            pulse_rr(2'd0, 4'd2);
         end
      join
      checks++;
      if (b !== 8'h40 || ok !== 1'b1) begin
         errors++;
         $display("FAIL ovr_a got %h ok=%b want 40 1", b, ok);
      end
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_flag got %b want 1", overrun);
      end
      rx_byte(b, g, ok);
      checks++;
      if (b !== 8'hAA || g !== 2 || ok !== 1'b1) begin
         errors++;
         $display("FAIL ovr_b got %h gap=%0d ok=%b want aa 2 1", b, g, ok);
      end
      rx_byte(b, g, ok);
      checks++;
      if (b !== 8'h82 || g !== 3 || ok !== 1'b1) begin
         errors++;
         $display("FAIL ovr_rr got %h gap=%0d ok=%b want 82 3 1", b, g, ok);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_after got busy=%b ovr=%b want 0 1",
                  busy, overrun);
      end
      debug = 1'b0;
      @(negedge clk);
      debug = 1'b1;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_clear got %b want 0", overrun);
      end
      @(negedge clk);
   endtask

   task automatic test_debug_drop();
      logic [7:0] b;
      int g;
      logic ok;
      logic quiet;
      pulse_fr(9'h1FF);
      fork
         rx_byte(b, g, ok);
         begin
            repeat (12) @(negedge clk);
            debug = 1'b0;
         end
      join
      checks++;
      if (b !== 8'h41 || ok !== 1'b1) begin
         errors++;
         $display("FAIL drop_a got %h ok=%b want 41 1", b, ok);
      end
      pulse_rr(2'd1, 4'd1);
      quiet = 1'b1;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1) quiet = 1'b0;
      end
      checks++;
      if (quiet !== 1'b1) begin
         errors++;
         $display("FAIL drop_quiet got %b want 1", quiet);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL drop_busy got %b want 0", busy);
      end
      debug = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic quiet;
      pulse_rr(2'd0, 4'd5);
      @(negedge clk);
      repeat (2 + 4 * CPB) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL mid_bit3 got %b want 0", tx);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got tx=%b busy=%b want 1 0", tx, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      quiet = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
      end
      checks++;
      if (quiet !== 1'b1) begin
         errors++;
         $display("FAIL mid_quiet got %b want 1", quiet);
      end
   endtask

   initial begin
      test_reset();
      test_rr();
      test_fr();
      test_back_to_back();
      test_overrun();
      test_debug_drop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
